// File: rtl/trigger_scheduler.sv
// trigger_scheduler: round-robin arbiter for edge-triggered requests; each grant waits a
// sampled delay, then emits a one-cycle one-hot trigger for the granted channel.
module trigger_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W = 8,
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] enable,
  input  logic [CNT_W-1:0]   delay,
  input  logic               abort,
  output logic [NUM_REQ-1:0] trigger,
  output logic               busy,
  output logic [ID_W-1:0]    active_id,
  output logic [NUM_REQ-1:0] pending,
  output logic               dropped
);
  typedef enum logic [1:0] {IDLE, COUNT, FIRE} state_t;
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [NUM_REQ-1:0] enable_q, request, grant, trigger_d;
  logic [ID_W-1:0] last_grant, last_d, id_d, winner, cand;
  logic found;
  assign request = enable & ~enable_q;
  assign busy = state != IDLE;
  // first pending channel at or after last_grant+1, wrapping
  always_comb begin
    winner = last_grant;
    cand = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && pending[cand]) begin
        winner = cand;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    id_d = active_id;
    last_d = last_grant;
    grant = '0;
    trigger_d = '0;
    case (state)
      IDLE: if (found) begin
        grant[winner] = 1'b1;
        id_d = winner;
        last_d = winner;
        cnt_d = delay;
        state_d = COUNT;
      end
      COUNT: if (abort) state_d = IDLE;
        else if (cnt == '0) begin
          state_d = FIRE;
          trigger_d[active_id] = 1'b1;
        end else cnt_d = cnt - CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      trigger <= '0;
      pending <= '0;
      dropped <= 1'b0;
      active_id <= '0;
      enable_q <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      trigger <= trigger_d;
      pending <= (pending | request) & ~grant;
      dropped <= dropped | |(request & pending);
      active_id <= id_d;
      enable_q <= enable;
      last_grant <= last_d;
    end
endmodule

// File: tb/tb_trigger_scheduler.sv
// tb_trigger_scheduler: directed vector table, corner sequences and a randomized run
// checked against a timestamp-based reference model.
module tb_trigger_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, abort = 1'b0;
  logic [3:0] enable = '0;
  logic [7:0] delay = '0;
  logic [3:0] trigger, pending;
  logic busy, dropped;
  logic [1:0] active_id;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  trigger_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .delay(delay), .abort(abort),
    .trigger(trigger), .busy(busy), .active_id(active_id), .pending(pending), .dropped(dropped)
  );
  typedef struct {
    logic rst; logic [3:0] en; logic [7:0] d; logic ab;
    logic [3:0] trig; logic bsy; logic [1:0] id; logic [3:0] pend; logic drop;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic r, input logic [3:0] en, input logic [7:0] d, input logic ab,
                     input logic [3:0] tr, input logic b, input logic [1:0] id,
                     input logic [3:0] p, input logic dr);
    vec_t v;
    v = '{r, en, d, ab, tr, b, id, p, dr};
    tbl.push_back(v);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic [3:0] tr, input logic b,
                         input logic [1:0] id, input logic [3:0] p, input logic dr);
    chk({nm, " trigger"}, 32'(trigger), 32'(tr));
    chk({nm, " busy"}, 32'(busy), 32'(b));
    chk({nm, " active_id"}, 32'(active_id), 32'(id));
    chk({nm, " pending"}, 32'(pending), 32'(p));
    chk({nm, " dropped"}, 32'(dropped), 32'(dr));
  endtask
  task automatic cyc(input logic [3:0] en, input logic [7:0] d, input logic ab);
    @(negedge clk);
    enable = en;
    delay = d;
    abort = ab;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    enable = '0;
    abort = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  // reference model: a grant at edge n with delay d schedules its trigger edge at n+d+1
  logic [3:0] m_pend, m_trig, m_en_prev;
  logic m_drop, m_active;
  logic [1:0] m_id, m_last;
  int m_n, m_fire;
  task automatic model_reset();
    m_pend = '0; m_trig = '0; m_en_prev = '0; m_drop = 1'b0; m_active = 1'b0;
    m_id = '0; m_last = 2'd3; m_n = 0; m_fire = 0;
  endtask
  task automatic model_step(input logic [3:0] en, input logic [7:0] d, input logic ab);
    logic [3:0] req, g;
    req = en & ~m_en_prev;
    m_en_prev = en;
    g = '0;
    m_n++;
    if (m_active) begin
      if (m_n <= m_fire && ab) begin m_active = 1'b0; m_trig = '0; end
      else if (m_n == m_fire) m_trig = 4'b0001 << m_id;
      else if (m_n > m_fire) begin m_active = 1'b0; m_trig = '0; end
    end else if (m_pend != '0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (int'(m_last) + k) % 4;
        if (g == '0 && m_pend[c]) begin
          g[c] = 1'b1;
          m_id = 2'(c);
          m_last = 2'(c);
        end
      end
      m_fire = m_n + int'(d) + 1;
      m_active = 1'b1;
    end
    m_drop = m_drop | |(req & m_pend);
    m_pend = (m_pend | req) & ~g;
  endtask
  initial begin
    int n0, n2, at;
    logic [3:0] en;
    logic [7:0] d;
    logic ab;
    // delay=5 on channel 0, then four simultaneous requests with delay=0
    add(1, 4'h0, 5, 0, 4'h0, 0, 0, 4'h0, 0);
    add(0, 4'h1, 5, 0, 4'h0, 0, 0, 4'h1, 0);
    add(0, 4'h1, 5, 0, 4'h0, 1, 0, 4'h0, 0);
    for (int i = 2; i <= 6; i++) add(0, 4'h1, 5, 0, 4'h0, 1, 0, 4'h0, 0);
    add(0, 4'h1, 5, 0, 4'h1, 1, 0, 4'h0, 0);
    add(0, 4'h1, 5, 1, 4'h0, 0, 0, 4'h0, 0);
    add(0, 4'h1, 5, 1, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0);
    add(0, 4'hF, 0, 0, 4'h0, 0, 0, 4'hF, 0);
    add(0, 4'hF, 0, 0, 4'h0, 1, 0, 4'hE, 0);
    add(0, 4'hF, 0, 0, 4'h1, 1, 0, 4'hE, 0);
    add(0, 4'hF, 0, 0, 4'h0, 0, 0, 4'hE, 0);
    add(0, 4'hF, 0, 0, 4'h0, 1, 1, 4'hC, 0);
    add(0, 4'hF, 0, 0, 4'h2, 1, 1, 4'hC, 0);
    add(0, 4'hF, 0, 0, 4'h0, 0, 1, 4'hC, 0);
    add(0, 4'hF, 0, 0, 4'h0, 1, 2, 4'h8, 0);
    add(0, 4'hF, 0, 0, 4'h4, 1, 2, 4'h8, 0);
    add(0, 4'hF, 0, 0, 4'h0, 0, 2, 4'h8, 0);
    add(0, 4'hF, 0, 0, 4'h0, 1, 3, 4'h0, 0);
    add(0, 4'hF, 0, 0, 4'h8, 1, 3, 4'h0, 0);
    add(0, 4'hF, 0, 0, 4'h0, 0, 3, 4'h0, 0);
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = !tbl[i].rst;
      enable = tbl[i].en;
      delay = tbl[i].d;
      abort = tbl[i].ab;
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].trig, tbl[i].bsy, tbl[i].id, tbl[i].pend, tbl[i].drop);
    end
    // re-request of the channel in service: first is queued, second is dropped
    do_reset();
    cyc(4'b0100, 10, 0);
    chk("rereq E0 pending", 32'(pending), 32'h4);
    cyc(4'b0100, 10, 0);
    chk("rereq grant id", 32'(active_id), 32'd2);
    cyc(4'b0000, 10, 0);
    cyc(4'b0100, 10, 0);
    chk("rereq queued", 32'(pending), 32'h4);
    chk("rereq not dropped", 32'(dropped), 32'h0);
    cyc(4'b0000, 10, 0);
    cyc(4'b0100, 10, 0);
    chk("rereq dropped", 32'(dropped), 32'h1);
    n2 = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(4'b0100, 10, 0);
      n2 += int'(trigger[2]);
    end
    chk("rereq fire count", 32'(n2), 32'd2);
    chk("rereq dropped sticky", 32'(dropped), 32'h1);
    // abort three cycles after grant; queued channel 2 is served next
    do_reset();
    cyc(4'b0001, 8, 0);
    cyc(4'b0001, 8, 0);
    chk("abort grant id", 32'(active_id), 32'd0);
    cyc(4'b0101, 8, 0);
    chk("abort pending", 32'(pending), 32'h4);
    cyc(4'b0101, 8, 0);
    cyc(4'b0101, 8, 1);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort pending kept", 32'(pending), 32'h4);
    cyc(4'b0101, 8, 0);
    chk("abort next id", 32'(active_id), 32'd2);
    chk("abort next busy", 32'(busy), 32'h1);
    n0 = 0;
    n2 = 0;
    at = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0101, 8, 0);
      n0 += int'(trigger[0]);
      n2 += int'(trigger[2]);
      if (trigger[2] && at < 0) at = i;
    end
    chk("abort ch0 fires", 32'(n0), 32'd0);
    chk("abort ch2 fires", 32'(n2), 32'd1);
    chk("abort ch2 fire time", 32'(at), 32'd8);
    // asynchronous reset mid-countdown with requests held through release
    do_reset();
    cyc(4'b0010, 20, 0);
    cyc(4'b0010, 20, 0);
    chk("rst busy before", 32'(busy), 32'h1);
    cyc(4'b0010, 20, 0);
    @(negedge clk);
    enable = 4'b1010;
    rst_n = 1'b0;
    #1;
    chk_all("rst async", 4'h0, 0, 0, 4'h0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst held request", 32'(pending), 32'hA);
    cyc(4'b1010, 20, 0);
    chk("rst first grant", 32'(active_id), 32'd1);
    chk("rst first pending", 32'(pending), 32'h8);
    n0 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(4'b1010, 20, 0);
      n0 += int'(trigger != '0);
    end
    chk("rst no trigger", 32'(n0), 32'd0);
    // delay change after grant is ignored
    do_reset();
    cyc(4'b0001, 5, 0);
    cyc(4'b0001, 5, 0);
    chk("delay grant busy", 32'(busy), 32'h1);
    for (int i = 2; i <= 9; i++) begin
      cyc(4'b0001, 1, 0);
      chk($sformatf("delay E%0d trigger", i), 32'(trigger), (i == 7) ? 32'h1 : 32'h0);
    end
    // randomized run against the model
    do_reset();
    model_reset();
    en = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      en ^= 4'($urandom) & 4'($urandom) & 4'($urandom);
      d = 8'($urandom_range(0, 6));
      ab = ($urandom_range(0, 15) == 0);
      enable = en;
      delay = d;
      abort = ab;
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all("rand reset", m_trig, m_active, m_id, m_pend, m_drop);
        @(posedge clk);
      end else begin
        rst_n = 1'b1;
        model_step(en, d, ab);
        @(posedge clk);
        #1;
        chk_all($sformatf("rand%0d", i), m_trig, m_active, m_id, m_pend, m_drop);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
